uart_tx_arbiter: RTL and testbench
==================================

// Module: uart_tx_arbiter
// PURPOSE
//  Shares one UART byte transmitter between NUM_REQ byte-stream sources.
//  Arbitration is round-robin and packet-locked: a grant is held until the byte flagged last is
//  accepted, or until the owner stalls for TIMEOUT_CYCLES.
//  An optional line-idle gap of GAP_CYCLES is inserted between packets.
//  The block sits between the producers and the UART TX byte interface.
// PARAMETERS
//  NUM_REQ        4    number of requesters (>=2)
//  DATA_W         8    byte width
//  GAP_CYCLES     16   idle clk cycles after each packet (0 = no gap)
//  TIMEOUT_CYCLES 1024 consecutive stall cycles of owner before forced release (0 = disabled)
// PORTS
//  clk          in   1               system clock
//  rst_n        in   1               asynchronous reset, active low
//  req_valid    in   NUM_REQ         per-requester byte valid
//  req_data     in   NUM_REQ*DATA_W  per-requester byte; requester i in bits [i*DATA_W +: DATA_W]
//  req_last     in   NUM_REQ         byte is the last of its packet
//  req_ready    out  NUM_REQ         byte accepted this cycle (owner only)
//  tx_data      out  DATA_W          byte to the UART transmitter
//  tx_valid     out  1               tx_data valid
//  tx_ready     in   1               UART transmitter accepts the byte
//  grant        out  NUM_REQ         one-hot current owner; 0 when there is no owner
//  busy         out  1               state != IDLE
//  timeout_evt  out  1               one-cycle pulse on forced release
// BEHAVIOUR
//  Reset (async, rst_n=0)
//   - state=IDLE; grant=0; busy=0; timeout_evt=0; counters=0.
//   - RR pointer=NUM_REQ-1, so requester 0 wins first.
//   - A reset mid-packet drops ownership immediately; the partial packet is not resumed.
//  FSM: IDLE -> XFER -> (GAP) -> IDLE
//   - IDLE
//     - Outputs: tx_valid=0; req_ready=0.
//     - If any req_valid: on the next edge, grant = first set bit searching from pointer+1 with
//       wrap-around; pointer <= winner; state <= XFER.
//     - Latency: req_valid rising at edge N gives grant and a possible first transfer in cycle N+1.
//   - XFER (combinational datapath through the owner g)
//     - tx_valid = req_valid[g]; tx_data = req_data[g]; req_ready[g] = tx_ready.
//     - Non-owners always see req_ready=0.
//     - Transfer occurs when tx_valid && tx_ready.
//     - Transfer with req_last[g]: grant <= 0; state <= GAP, or IDLE if GAP_CYCLES=0.
//     - req_last without a transfer has no effect.
//     - Stall counter increments in each cycle with req_valid[g]=0 and clears on any transfer.
//       A cycle with req_valid[g]=1 && tx_ready=0 is not a stall.
//     - Timeout: on the edge where the stall counter would reach TIMEOUT_CYCLES, grant <= 0,
//       timeout_evt=1 for one cycle, state <= GAP.
//   - GAP
//     - Outputs: tx_valid=0; req_ready=0.
//     - Gap counter counts GAP_CYCLES cycles, then state <= IDLE.
//     - Requests arriving during GAP wait.
//  Arithmetic and width
//   - Counters are $clog2(max+1) bits and never wrap.
//   - The pointer wraps from NUM_REQ-1 to 0.
//  Simultaneous events
//   - Transfer with last and timeout expiring in the same cycle: treated as a normal end;
//     timeout_evt=0.
//   - Several requesters becoming valid in one cycle: RR order decides the winner.
//   - The just-served requester has lowest priority in the next arbitration.
// TESTING
//  T1 Reset/idle: rst_n=0, then 1; no requests
//     -> grant=0, tx_valid=0, busy=0, timeout_evt=0 for 100 cycles.
//  T2 Single packet: req0 sends 3 bytes 0x41,0x42,0x43 (last on 0x43), tx_ready always 1,
//     GAP_CYCLES=16
//     -> grant=4'b0001 one cycle after request; tx_data 0x41,0x42,0x43 on consecutive cycles;
//        IDLE 16 cycles after the last byte.
//  T3 Round-robin: req0..3 each hold 1-byte packets continuously
//     -> grant order 0,1,2,3,0; no byte from a non-owner ever reaches tx_data.
//  T4 Packet lock: req1 owns a 4-byte packet; req2 asserts mid-packet; tx_ready toggles 1/0
//     -> all 4 req1 bytes are sent before grant moves to req2; no byte lost or duplicated.
//  T5 Timeout: TIMEOUT_CYCLES=8; req3 sends 1 non-last byte, then drops valid
//     -> exactly 8 stall cycles later timeout_evt pulses once; grant=0; next requester served
//        after the gap.
//  T6 Async reset mid-packet: rst_n low for 3 ns between clock edges during a req2 transfer
//     -> grant, tx_valid and busy go to 0 immediately; after release req0 wins first.

Source files
------------

// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: shares one UART byte transmitter between NUM_REQ byte-stream
// sources. Round-robin arbitration that holds the grant until the owner's last byte
// is accepted or the owner stalls too long. An optional idle gap follows each packet.
//
// state   | meaning
// --------+----------------------------------------------------------------
// ST_IDLE | no owner; arbitrate among req_valid on the next edge
// ST_XFER | owner holds the transmitter; bytes flow combinationally
// ST_GAP  | line kept idle for GAP_CYCLES cycles after a packet or timeout

module uart_tx_arbiter #(
  parameter int NUM_REQ        = 4,
  parameter int DATA_W         = 8,
  parameter int GAP_CYCLES     = 16,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [NUM_REQ*DATA_W-1:0] req_data,
  input  logic [NUM_REQ-1:0]        req_last,
  output logic [NUM_REQ-1:0]        req_ready,
  output logic [DATA_W-1:0]         tx_data,
  output logic                      tx_valid,
  input  logic                      tx_ready,
  output logic [NUM_REQ-1:0]        grant,
  output logic                      busy,
  output logic                      timeout_evt
);

  localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int GAP_W = (GAP_CYCLES > 0) ? $clog2(GAP_CYCLES + 1) : 1;
  localparam int TO_W  = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;

  // Terminal-count values: the counters stop one short of the limit, because the
  // edge that would make them reach it is the edge that acts.
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);
  localparam logic [TO_W-1:0]  TO_LAST  = TO_W'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);
  localparam logic [PTR_W-1:0] PTR_RST  = PTR_W'(NUM_REQ - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_XFER = 2'd1,
    ST_GAP  = 2'd2
  } state_t;

  state_t             state_q;
  logic [NUM_REQ-1:0] grant_q;
  logic [PTR_W-1:0]   owner_q;
  logic [PTR_W-1:0]   ptr_q;
  logic [GAP_W-1:0]   gap_q;
  logic [TO_W-1:0]    stall_q;
  logic               timeout_evt_q;

  // Arbitration result, only consumed in ST_IDLE
  logic [PTR_W-1:0]   win_idx_d;
  logic [NUM_REQ-1:0] win_oh_d;

  // Owner-selected stream
  logic [DATA_W-1:0]  sel_data;
  logic               sel_valid;
  logic               sel_last;
  logic               xfer;

  // Round-robin search starting one past the last winner, with wrap-around
  always_comb begin
    logic             found;
    logic [PTR_W-1:0] idx;
    found     = 1'b0;
    idx       = '0;
    win_idx_d = ptr_q;
    for (int i = 1; i <= NUM_REQ; i++) begin
      idx = PTR_W'((int'(ptr_q) + i) % NUM_REQ);
      if (!found && req_valid[idx]) begin
        found     = 1'b1;
        win_idx_d = idx;
      end
    end
    win_oh_d            = '0;
    win_oh_d[win_idx_d] = 1'b1;
  end

  // Mux the owner's byte, valid and last flag
  always_comb begin
    sel_data  = '0;
    sel_valid = 1'b0;
    sel_last  = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (owner_q == PTR_W'(i)) begin
        sel_data  = req_data[i*DATA_W +: DATA_W];
        sel_valid = req_valid[i];
        sel_last  = req_last[i];
      end
    end
  end

  // Datapath is only open in ST_XFER; non-owners never see ready
  always_comb begin
    tx_valid  = (state_q == ST_XFER) && sel_valid;
    tx_data   = (state_q == ST_XFER) ? sel_data : '0;
    req_ready = (state_q == ST_XFER) ? (grant_q & {NUM_REQ{tx_ready}}) : '0;
    xfer      = tx_valid && tx_ready;
  end

  // Arbitration / packet-lock FSM with its counters and registered status outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= ST_IDLE;
      grant_q       <= '0;
      owner_q       <= '0;
      ptr_q         <= PTR_RST;
      gap_q         <= '0;
      stall_q       <= '0;
      timeout_evt_q <= 1'b0;
    end else begin
      timeout_evt_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (|req_valid) begin
            grant_q <= win_oh_d;
            owner_q <= win_idx_d;
            ptr_q   <= win_idx_d;
            stall_q <= '0;
            state_q <= ST_XFER;
          end
        end

        ST_XFER: begin
          if (xfer && sel_last) begin
            // A normal end wins over any timeout in the same cycle.
            grant_q <= '0;
            stall_q <= '0;
            gap_q   <= '0;
            state_q <= (GAP_CYCLES > 0) ? ST_GAP : ST_IDLE;
          end else if (xfer) begin
            stall_q <= '0;
          end else if (!sel_valid && (TIMEOUT_CYCLES > 0)) begin
            // Only an owner with nothing to offer is stalling; backpressure is not.
            if (stall_q == TO_LAST) begin
              grant_q       <= '0;
              stall_q       <= '0;
              gap_q         <= '0;
              timeout_evt_q <= 1'b1;
              state_q       <= (GAP_CYCLES > 0) ? ST_GAP : ST_IDLE;
            end else begin
              stall_q <= stall_q + 1'b1;
            end
          end
        end

        ST_GAP: begin
          if (gap_q == GAP_LAST) begin
            gap_q   <= '0;
            state_q <= ST_IDLE;
          end else begin
            gap_q <= gap_q + 1'b1;
          end
        end

        default: begin
          grant_q <= '0;
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign grant       = grant_q;
  assign busy        = (state_q != ST_IDLE);
  assign timeout_evt = timeout_evt_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb_uart_tx_arbiter: directed bench for uart_tx_arbiter (GAP_CYCLES=16, TIMEOUT_CYCLES=8).
// Inputs change 1 ns after the rising edge; outputs are sampled on the falling edge.

module tb_uart_tx_arbiter;

  logic        clk;
  logic        rst_n;
  logic [3:0]  req_valid;
  logic [31:0] req_data;
  logic [3:0]  req_last;
  logic [3:0]  req_ready;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready;
  logic [3:0]  grant;
  logic        busy;
  logic        timeout_evt;

  int n_chk;
  int n_bad;

  // Per-requester byte sources: {last, data}
  logic [8:0] src_mem [4][16];
  int         src_len [4];
  int         src_pos [4];

  // Log of accepted transfers
  logic [7:0] log_data  [64];
  logic [3:0] log_grant [64];
  int         n_log;
  logic       tgl;
  logic       nonowner_seen;

  uart_tx_arbiter #(
    .NUM_REQ       (4),
    .DATA_W        (8),
    .GAP_CYCLES    (16),
    .TIMEOUT_CYCLES(8)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_data   (req_data),
    .req_last   (req_last),
    .req_ready  (req_ready),
    .tx_data    (tx_data),
    .tx_valid   (tx_valid),
    .tx_ready   (tx_ready),
    .grant      (grant),
    .busy       (busy),
    .timeout_evt(timeout_evt)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h want 0x%0h", tag, act, exp);
    end
  endtask

  task automatic drive_srcs();
    for (int i = 0; i < 4; i++) begin
      if (src_pos[i] < src_len[i]) begin
        req_valid[i]        = 1'b1;
        req_data[i*8 +: 8]  = src_mem[i][src_pos[i]][7:0];
        req_last[i]         = src_mem[i][src_pos[i]][8];
      end else begin
        req_valid[i]        = 1'b0;
        req_data[i*8 +: 8]  = 8'h00;
        req_last[i]         = 1'b0;
      end
    end
  endtask

  task automatic load(input int r, input logic last, input logic [7:0] d);
    src_mem[r][src_len[r]] = {last, d};
    src_len[r]++;
  endtask

  task automatic clear_srcs();
    for (int i = 0; i < 4; i++) begin
      src_len[i] = 0;
      src_pos[i] = 0;
    end
    for (int k = 0; k < 64; k++) begin
      log_data[k]  = 8'h00;
      log_grant[k] = 4'h0;
    end
    n_log         = 0;
    nonowner_seen = 1'b0;
  endtask

  // One clock cycle: drive after the edge, observe on the falling edge, advance sources
  task automatic cycle();
    @(posedge clk);
    #1;
    drive_srcs();
    tx_ready = tgl ? ~tx_ready : 1'b1;
    @(negedge clk);
    if (tx_valid && tx_ready && n_log < 64) begin
      log_data[n_log]  = tx_data;
      log_grant[n_log] = grant;
      n_log++;
    end
    if ((req_ready & ~grant) != 4'b0000) nonowner_seen = 1'b1;
    for (int i = 0; i < 4; i++)
      if (req_ready[i]) src_pos[i]++;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n    = 1'b0;
    tgl      = 1'b0;
    tx_ready = 1'b1;
    clear_srcs();
    drive_srcs();
    #3;
    rst_n = 1'b1;
  endtask

  initial begin
    logic [7:0] t4_data [5];
    logic [3:0] t4_grant [5];
    n_chk    = 0;
    n_bad    = 0;
    rst_n    = 1'b0;
    tgl      = 1'b0;
    tx_ready = 1'b1;
    clear_srcs();
    drive_srcs();
    #12;
    rst_n = 1'b1;

    // T1: idle after reset
    for (int k = 0; k < 100; k++) begin
      cycle();
      check_eq("t1_idle", 32'({grant, tx_valid, busy, timeout_evt}), 32'h0);
    end

    // T2: single 3-byte packet from req0, then 16-cycle gap
    load(0, 1'b0, 8'h41);
    load(0, 1'b0, 8'h42);
    load(0, 1'b1, 8'h43);
    cycle();
    check_eq("t2_wait_grant", 32'(grant), 32'h0);
    for (int k = 0; k < 3; k++) begin
      cycle();
      check_eq("t2_grant", 32'(grant), 32'h1);
      check_eq("t2_valid", 32'(tx_valid), 32'h1);
      check_eq("t2_data", 32'(tx_data), 32'h41 + 32'(k));
      check_eq("t2_ready", 32'(req_ready), 32'h1);
    end
    cycle();
    check_eq("t2_gap_grant", 32'(grant), 32'h0);
    check_eq("t2_gap_valid", 32'(tx_valid), 32'h0);
    check_eq("t2_gap_busy", 32'(busy), 32'h1);
    for (int k = 0; k < 15; k++) cycle();
    check_eq("t2_gap_end_busy", 32'(busy), 32'h1);
    cycle();
    check_eq("t2_idle_busy", 32'(busy), 32'h0);

    // T3: round-robin among four continuous 1-byte packet streams
    do_reset();
    for (int i = 0; i < 4; i++) begin
      load(i, 1'b1, 8'hA0 + 8'(i));
      load(i, 1'b1, 8'hA0 + 8'(i));
    end
    for (int k = 0; k < 200 && n_log < 5; k++) cycle();
    check_eq("t3_count", 32'(n_log), 32'd5);
    for (int k = 0; k < 5; k++) begin
      check_eq("t3_grant", 32'(log_grant[k]), 32'(1) << (k % 4));
      check_eq("t3_data", 32'(log_data[k]), 32'hA0 + 32'(k % 4));
    end
    check_eq("t3_nonowner", 32'(nonowner_seen), 32'h0);

    // T4: packet lock with toggling tx_ready; req2 arrives mid-packet
    do_reset();
    tgl = 1'b1;
    load(1, 1'b0, 8'h10);
    load(1, 1'b0, 8'h11);
    load(1, 1'b0, 8'h12);
    load(1, 1'b1, 8'h13);
    t4_data  = '{8'h10, 8'h11, 8'h12, 8'h13, 8'h20};
    t4_grant = '{4'b0010, 4'b0010, 4'b0010, 4'b0010, 4'b0100};
    for (int k = 0; k < 200 && n_log < 5; k++) begin
      if (src_pos[1] >= 2 && src_len[2] == 0) load(2, 1'b1, 8'h20);
      cycle();
    end
    check_eq("t4_count", 32'(n_log), 32'd5);
    for (int k = 0; k < 5; k++) begin
      check_eq("t4_data", 32'(log_data[k]), 32'(t4_data[k]));
      check_eq("t4_grant", 32'(log_grant[k]), 32'(t4_grant[k]));
    end
    check_eq("t4_nonowner", 32'(nonowner_seen), 32'h0);

    // T5: req3 stalls after one non-last byte; timeout after 8 stall cycles
    do_reset();
    load(3, 1'b0, 8'h33);
    cycle();
    check_eq("t5_wait_grant", 32'(grant), 32'h0);
    cycle();
    check_eq("t5_grant", 32'(grant), 32'h8);
    check_eq("t5_data", 32'(tx_data), 32'h33);
    for (int k = 2; k <= 9; k++) begin
      if (k == 3) load(0, 1'b1, 8'h05);
      cycle();
    end
    check_eq("t5_hold_grant", 32'(grant), 32'h8);
    check_eq("t5_hold_evt", 32'(timeout_evt), 32'h0);
    check_eq("t5_hold_valid", 32'(tx_valid), 32'h0);
    cycle();
    check_eq("t5_evt", 32'(timeout_evt), 32'h1);
    check_eq("t5_rel_grant", 32'(grant), 32'h0);
    check_eq("t5_rel_busy", 32'(busy), 32'h1);
    cycle();
    check_eq("t5_evt_once", 32'(timeout_evt), 32'h0);
    for (int k = 0; k < 14; k++) cycle();
    check_eq("t5_gap_busy", 32'(busy), 32'h1);
    cycle();
    check_eq("t5_idle_busy", 32'(busy), 32'h0);
    check_eq("t5_idle_grant", 32'(grant), 32'h0);
    cycle();
    check_eq("t5_next_grant", 32'(grant), 32'h1);
    check_eq("t5_next_data", 32'(tx_data), 32'h05);

    // T6: asynchronous reset in the middle of a req2 packet
    do_reset();
    load(2, 1'b0, 8'h61);
    load(2, 1'b0, 8'h62);
    load(2, 1'b0, 8'h63);
    load(2, 1'b1, 8'h64);
    cycle();
    cycle();
    check_eq("t6_grant", 32'(grant), 32'h4);
    check_eq("t6_data0", 32'(tx_data), 32'h61);
    cycle();
    check_eq("t6_data1", 32'(tx_data), 32'h62);
    check_eq("t6_busy", 32'(busy), 32'h1);
    rst_n = 1'b0;
    load(0, 1'b1, 8'h07);
    drive_srcs();
    #1;
    check_eq("t6_rst_grant", 32'(grant), 32'h0);
    check_eq("t6_rst_valid", 32'(tx_valid), 32'h0);
    check_eq("t6_rst_busy", 32'(busy), 32'h0);
    #2;
    rst_n = 1'b1;
    cycle();
    check_eq("t6_after_grant", 32'(grant), 32'h1);
    check_eq("t6_after_data", 32'(tx_data), 32'h07);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
